systolic_matmul_engine: RTL and testbench

Self-contained SIZE×SIZE output-stationary systolic matrix multiplier computing C = A·B, with the input skew, FSM and handshake built in. It replaces hand-skewed stimulus with a column/row beat interface, adds stall tolerance, a runtime signed/unsigned mode and a completion pulse. It sits between the operand buffers and the result readout in the accelerator datapath.

---
 rtl/systolic_matmul_engine.sv | 182 ++++++++++++++++++
 tb/tb_systolic_matmul_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul_engine.sv
// Output-stationary SIZE x SIZE systolic multiplier computing C = A*B from column/row beats.
// Operand skew, job FSM and completion pulse are built in; bubbles are injected as zeros.
module systolic_matmul_engine #(
   parameter int SIZE   = 8,
   parameter int I_BITS = 8,
   parameter int O_BITS = 2*I_BITS + $clog2(SIZE)
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_start,
   input  logic                        i_signed,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [SIZE*I_BITS-1:0]      i_a_full,
   input  logic [SIZE*I_BITS-1:0]      i_b_full,
   output logic [SIZE*SIZE*O_BITS-1:0] o_c_full,
   output logic                        o_busy,
   output logic                        o_done
);

   localparam int BEAT_W  = $clog2(SIZE);
   localparam int FLUSH_W = $clog2(2*SIZE);
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(SIZE-1);
   localparam logic [FLUSH_W-1:0] FLUSH_LEN = FLUSH_W'(2*SIZE-1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} state_t;

   state_t               state_reg, state_next;
   logic [BEAT_W-1:0]    beat_cnt_reg;
   logic [FLUSH_W-1:0]   flush_cnt_reg;
   logic                 signed_reg;
   logic                 start_fire, beat_fire, last_beat;

   assign start_fire = i_start && (state_reg == ST_IDLE);
   assign beat_fire  = i_valid && (state_reg == ST_LOAD);
   assign last_beat  = beat_fire && (beat_cnt_reg == LAST_BEAT);

   function automatic logic [O_BITS-1:0] extend(input logic [I_BITS-1:0] v, input logic sgn);
      return sgn ? {{(O_BITS-I_BITS){v[I_BITS-1]}}, v} : {{(O_BITS-I_BITS){1'b0}}, v};
   endfunction

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (i_start) state_next = ST_LOAD;
         ST_LOAD:  if (last_beat) state_next = ST_FLUSH;
         ST_FLUSH: if (flush_cnt_reg == '0) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (state_reg)
         ST_LOAD:  begin o_ready = 1'b1; o_busy = 1'b1; end
         ST_FLUSH: o_busy = 1'b1;
         ST_DONE:  begin o_busy = 1'b1; o_done = 1'b1; end
         default:  ;
      endcase
   end

   // The flush counter is loaded by the final beat and runs until the deepest PE has accumulated it.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         beat_cnt_reg  <= '0;
         flush_cnt_reg <= '0;
         signed_reg    <= 1'b0;
      end else begin
         if (start_fire) begin
            beat_cnt_reg <= '0;
            signed_reg   <= i_signed;
         end else if (beat_fire) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
         end
         if (last_beat)
            flush_cnt_reg <= FLUSH_LEN;
         else if ((state_reg == ST_FLUSH) && (flush_cnt_reg != '0))
            flush_cnt_reg <= flush_cnt_reg - 1'b1;
      end
   end

   logic [I_BITS-1:0] a_west  [SIZE];
   logic [I_BITS-1:0] b_north [SIZE];

   genvar gi, gj;
   generate
      for (gi = 0; gi < SIZE; gi++) begin : g_lane
         logic [I_BITS-1:0] a_inj, b_inj;
         assign a_inj = beat_fire ? i_a_full[gi*I_BITS +: I_BITS] : '0;
         assign b_inj = beat_fire ? i_b_full[gi*I_BITS +: I_BITS] : '0;

         if (gi == 0) begin : g_direct
            assign a_west[gi]  = a_inj;
            assign b_north[gi] = b_inj;
         end else begin : g_chain
            logic [I_BITS-1:0] a_chain_reg [gi];
            logic [I_BITS-1:0] b_chain_reg [gi];
            always_ff @(posedge i_clock or negedge i_reset) begin
               if (!i_reset) begin
                  for (int j = 0; j < gi; j++) begin
                     a_chain_reg[j] <= '0;
                     b_chain_reg[j] <= '0;
                  end
               end else if (start_fire) begin
                  for (int j = 0; j < gi; j++) begin
                     a_chain_reg[j] <= '0;
                     b_chain_reg[j] <= '0;
                  end
               end else begin
                  a_chain_reg[0] <= a_inj;
                  b_chain_reg[0] <= b_inj;
                  for (int j = 1; j < gi; j++) begin
                     a_chain_reg[j] <= a_chain_reg[j-1];
                     b_chain_reg[j] <= b_chain_reg[j-1];
                  end
               end
            end
            assign a_west[gi]  = a_chain_reg[gi-1];
            assign b_north[gi] = b_chain_reg[gi-1];
         end
      end
   endgenerate

   // Last column / last row outputs go nowhere, so the links are one short.
   logic [I_BITS-1:0] a_east  [SIZE][SIZE-1];
   logic [I_BITS-1:0] b_south [SIZE-1][SIZE];

   generate
      for (gi = 0; gi < SIZE; gi++) begin : g_row
         for (gj = 0; gj < SIZE; gj++) begin : g_col
            logic [I_BITS-1:0] a_in, b_in, a_pe_reg, b_pe_reg;
            logic [O_BITS-1:0] acc_reg, prod;

            if (gj == 0) begin : g_a_edge
               assign a_in = a_west[gi];
            end else begin : g_a_link
               assign a_in = a_east[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
               assign b_in = b_north[gj];
            end else begin : g_b_link
               assign b_in = b_south[gi-1][gj];
            end
            if (gj < SIZE-1) begin : g_a_out
               assign a_east[gi][gj] = a_pe_reg;
            end
            if (gi < SIZE-1) begin : g_b_out
               assign b_south[gi][gj] = b_pe_reg;
            end

            assign prod = extend(a_pe_reg, signed_reg) * extend(b_pe_reg, signed_reg);

            always_ff @(posedge i_clock or negedge i_reset) begin
               if (!i_reset) begin
                  a_pe_reg <= '0;
                  b_pe_reg <= '0;
                  acc_reg  <= '0;
               end else if (start_fire) begin
                  a_pe_reg <= '0;
                  b_pe_reg <= '0;
                  acc_reg  <= '0;
               end else begin
                  a_pe_reg <= a_in;
                  b_pe_reg <= b_in;
                  acc_reg  <= acc_reg + prod;
               end
            end

            assign o_c_full[(gi*SIZE+gj)*O_BITS +: O_BITS] = acc_reg;
         end
      end
   endgenerate

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Scoreboard bench for systolic_matmul_engine: reference products are queued at job start
// and compared when o_done fires, alongside handshake and completion timing.
module tb_systolic_matmul_engine;

   localparam int SIZE   = 8;
   localparam int I_BITS = 8;
   localparam int O_BITS = 2*I_BITS + $clog2(SIZE);
   localparam int CW     = SIZE*SIZE*O_BITS;

   logic                   clock = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   start = 1'b0;
   logic                   sgn = 1'b0;
   logic                   valid = 1'b0;
   logic                   ready;
   logic [SIZE*I_BITS-1:0] a_bus = '0;
   logic [SIZE*I_BITS-1:0] b_bus = '0;
   logic [CW-1:0]          c_bus;
   logic                   busy;
   logic                   done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_edge = 0;
   int start_edge = 0;
   int mat_a [SIZE][SIZE];
   int mat_b [SIZE][SIZE];
   logic [CW-1:0] exp_q [$];

   systolic_matmul_engine #(.SIZE(SIZE), .I_BITS(I_BITS), .O_BITS(O_BITS)) dut (
      .i_clock  (clock),
      .i_reset  (reset_n),
      .i_start  (start),
      .i_signed (sgn),
      .i_valid  (valid),
      .o_ready  (ready),
      .i_a_full (a_bus),
      .i_b_full (b_bus),
      .o_c_full (c_bus),
      .o_busy   (busy),
      .o_done   (done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int sx(input int v, input bit s);
      return (s && v >= 128) ? v - 256 : v;
   endfunction

   function automatic logic [CW-1:0] model(input bit s);
      logic [CW-1:0] res;
      logic [31:0]   u;
      int            acc;
      res = '0;
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++) begin
            acc = 0;
            for (int k = 0; k < SIZE; k++) acc += sx(mat_a[r][k], s) * sx(mat_b[k][c], s);
            u = acc;
            res[(r*SIZE+c)*O_BITS +: O_BITS] = u[O_BITS-1:0];
         end
      return res;
   endfunction

   function automatic logic [O_BITS-1:0] elem(input logic [CW-1:0] v, input int idx);
      return v[idx*O_BITS +: O_BITS];
   endfunction

   function automatic int first_diff(input logic [CW-1:0] x, input logic [CW-1:0] y);
      for (int i = 0; i < SIZE*SIZE; i++)
         if (elem(x, i) !== elem(y, i)) return i;
      return 0;
   endfunction

   function automatic logic [CW-1:0] pop_expected();
      if (exp_q.size() == 0) return '1;
      return exp_q.pop_front();
   endfunction

   task automatic fill_random();
      for (int r = 0; r < SIZE; r++)
         for (int k = 0; k < SIZE; k++) begin
            mat_a[r][k] = $urandom_range(0, 255);
            mat_b[r][k] = $urandom_range(0, 255);
         end
   endtask

   task automatic fill_const(input int av, input int bv);
      for (int r = 0; r < SIZE; r++)
         for (int k = 0; k < SIZE; k++) begin
            mat_a[r][k] = av;
            mat_b[r][k] = bv;
         end
   endtask

   // Starts a job, then offers SIZE beats with optional random stalls carrying junk data.
   task automatic drive_job(input bit s, input int max_stall, input bit poke_start,
                            output logic ready_seen, output logic [CW-1:0] c_after_start);
      int n;
      @(negedge clock);
      start = 1'b1;
      sgn   = s;
      exp_q.push_back(model(s));
      @(negedge clock);
      start      = 1'b0;
      sgn        = ~s;
      start_edge = cyc;
      ready_seen = ready;
      c_after_start = c_bus;
      for (int k = 0; k < SIZE; k++) begin
         n = (max_stall > 0) ? $urandom_range(1, max_stall) : 0;
         for (int i = 0; i < n; i++) begin
            valid = 1'b0;
            start = poke_start;
            a_bus = {$urandom, $urandom};
            b_bus = {$urandom, $urandom};
            @(negedge clock);
         end
         start = 1'b0;
         valid = 1'b1;
         for (int r = 0; r < SIZE; r++) begin
            a_bus[r*I_BITS +: I_BITS] = I_BITS'(mat_a[r][k]);
            b_bus[r*I_BITS +: I_BITS] = I_BITS'(mat_b[k][r]);
         end
         @(negedge clock);
      end
      valid = 1'b0;
      a_bus = '0;
      b_bus = '0;
      last_edge = cyc;
   endtask

   task automatic wait_done(input bit poke_flush, output int done_edge);
      done_edge = -1;
      for (int i = 0; i < 200; i++) begin
         start = poke_flush && (i == 2 || i == 5);
         @(negedge clock);
         if (done) begin
            done_edge = cyc;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++;
      if (c_bus !== '0) begin errors++; $display("FAIL reset_c got C[%0d]=%0h want 0", first_diff(c_bus, '0), elem(c_bus, first_diff(c_bus, '0))); end
      $display("reset: outputs sampled while reset held");
   endtask

   task automatic test_identity();
      logic rdy;
      logic [CW-1:0] c0, expv;
      int de, ix;
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++) begin
            mat_a[r][c] = (r == c) ? 1 : 0;
            mat_b[r][c] = 8*r + c;
         end
      drive_job(1'b0, 0, 1'b0, rdy, c0);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL identity_ready got %b want 1", rdy); end
      wait_done(1'b0, de);
      checks++;
      if (de !== last_edge + 2*SIZE) begin errors++; $display("FAIL identity_done_edge got %0d want %0d", de, last_edge + 2*SIZE); end
      expv = pop_expected();
      ix = first_diff(c_bus, expv);
      checks++;
      if (c_bus !== expv) begin errors++; $display("FAIL identity_result C[%0d] got %0h want %0h", ix, elem(c_bus, ix), elem(expv, ix)); end
      checks++;
      if (elem(c_bus, 2*SIZE+3) !== O_BITS'(19)) begin errors++; $display("FAIL identity_c23 got %0d want 19", elem(c_bus, 2*SIZE+3)); end
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL identity_after_done done=%b busy=%b want 0 0", done, busy); end
      $display("identity: last_beat=%0d done=%0d", last_edge, de);
   endtask

   task automatic test_extremes();
      int av [3] = '{255, 128, 128};
      int bv [3] = '{255, 128, 127};
      bit sv [3] = '{1'b0, 1'b1, 1'b1};
      logic [O_BITS-1:0] want [3];
      logic rdy;
      logic [CW-1:0] c0, expv;
      int de, ix;
      want[0] = 19'd520200;
      want[1] = 19'd131072;
      want[2] = 19'h60400;
      for (int t = 0; t < 3; t++) begin
         fill_const(av[t], bv[t]);
         drive_job(sv[t], 0, 1'b0, rdy, c0);
         wait_done(1'b0, de);
         checks++;
         if (de !== last_edge + 2*SIZE) begin errors++; $display("FAIL extreme%0d_done_edge got %0d want %0d", t, de, last_edge + 2*SIZE); end
         expv = pop_expected();
         ix = first_diff(c_bus, expv);
         checks++;
         if (c_bus !== expv) begin errors++; $display("FAIL extreme%0d_result C[%0d] got %0h want %0h", t, ix, elem(c_bus, ix), elem(expv, ix)); end
         checks++;
         if (elem(c_bus, 5*SIZE+6) !== want[t]) begin errors++; $display("FAIL extreme%0d_c56 got %0h want %0h", t, elem(c_bus, 5*SIZE+6), want[t]); end
         $display("extreme%0d: signed=%0d C[5][6]=%0h", t, sv[t], elem(c_bus, 5*SIZE+6));
      end
   endtask

   task automatic test_stalls();
      logic rdy;
      logic [CW-1:0] c0, expv;
      int de, ix;
      bit s;
      for (int t = 0; t < 3; t++) begin
         fill_random();
         s = 1'($urandom_range(0, 1));
         drive_job(s, 5, 1'b0, rdy, c0);
         wait_done(1'b0, de);
         checks++;
         if (de !== last_edge + 2*SIZE) begin errors++; $display("FAIL stall%0d_done_edge got %0d want %0d", t, de, last_edge + 2*SIZE); end
         expv = pop_expected();
         ix = first_diff(c_bus, expv);
         checks++;
         if (c_bus !== expv) begin errors++; $display("FAIL stall%0d_result C[%0d] got %0h want %0h", t, ix, elem(c_bus, ix), elem(expv, ix)); end
         $display("stall%0d: signed=%0d start=%0d last_beat=%0d done=%0d", t, s, start_edge, last_edge, de);
      end
   endtask

   task automatic test_ignored_controls();
      logic rdy;
      logic [CW-1:0] c0, expv;
      int de, ix;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         valid = 1'b1;
         a_bus = {$urandom, $urandom};
         b_bus = {$urandom, $urandom};
      end
      @(negedge clock);
      valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL idle_valid busy=%b ready=%b want 0 0", busy, ready); end
      fill_random();
      drive_job(1'b1, 3, 1'b1, rdy, c0);
      wait_done(1'b1, de);
      start = 1'b1;
      checks++;
      if (de !== last_edge + 2*SIZE) begin errors++; $display("FAIL ignored_done_edge got %0d want %0d", de, last_edge + 2*SIZE); end
      expv = pop_expected();
      ix = first_diff(c_bus, expv);
      checks++;
      if (c_bus !== expv) begin errors++; $display("FAIL ignored_result C[%0d] got %0h want %0h", ix, elem(c_bus, ix), elem(expv, ix)); end
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL done_start busy=%b ready=%b want 0 0", busy, ready); end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || c_bus !== expv) begin errors++; $display("FAIL done_start_hold busy=%b want 0", busy); end
      $display("ignored: last_beat=%0d done=%0d", last_edge, de);
   endtask

   task automatic test_reset_mid();
      logic rdy;
      logic [CW-1:0] c0, expv;
      logic [CW-1:0] junk;
      int de, ix;
      fill_random();
      drive_job(1'b0, 0, 1'b0, rdy, c0);
      repeat (5) @(negedge clock);
      reset_n = 1'b0;
      junk = pop_expected();
      #1;
      checks++;
      if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl busy=%b ready=%b done=%b want 0 0 0", busy, ready, done); end
      checks++;
      if (c_bus !== '0) begin errors++; $display("FAIL midreset_c C[%0d] got %0h want 0", first_diff(c_bus, '0), elem(c_bus, first_diff(c_bus, '0))); end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      fill_const(1, 1);
      drive_job(1'b0, 0, 1'b0, rdy, c0);
      wait_done(1'b0, de);
      checks++;
      if (de !== last_edge + 2*SIZE) begin errors++; $display("FAIL postreset_done_edge got %0d want %0d", de, last_edge + 2*SIZE); end
      expv = pop_expected();
      ix = first_diff(c_bus, expv);
      checks++;
      if (c_bus !== expv) begin errors++; $display("FAIL postreset_result C[%0d] got %0h want %0h", ix, elem(c_bus, ix), elem(expv, ix)); end
      checks++;
      if (elem(c_bus, SIZE*SIZE-1) !== O_BITS'(8)) begin errors++; $display("FAIL postreset_c77 got %0d want 8", elem(c_bus, SIZE*SIZE-1)); end
      $display("reset_mid: discarded job, new job done=%0d", de);
   endtask

   task automatic test_back_to_back();
      logic rdy;
      logic [CW-1:0] c0, expv;
      int de, ix;
      for (int t = 0; t < 2; t++) begin
         fill_random();
         drive_job(t[0], 0, 1'b0, rdy, c0);
         checks++;
         if (c0 !== '0) begin errors++; $display("FAIL b2b%0d_start_clear C[%0d] got %0h want 0", t, first_diff(c0, '0), elem(c0, first_diff(c0, '0))); end
         wait_done(1'b0, de);
         checks++;
         if (de !== start_edge + 3*SIZE) begin errors++; $display("FAIL b2b%0d_done_edge got %0d want %0d", t, de, start_edge + 3*SIZE); end
         expv = pop_expected();
         ix = first_diff(c_bus, expv);
         checks++;
         if (c_bus !== expv) begin errors++; $display("FAIL b2b%0d_result C[%0d] got %0h want %0h", t, ix, elem(c_bus, ix), elem(expv, ix)); end
         $display("b2b%0d: signed=%0d start=%0d done=%0d", t, t, start_edge, de);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      test_reset();
      reset_n = 1'b1;
      @(negedge clock);
      test_identity();
      test_extremes();
      test_stalls();
      test_ignored_controls();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
